// File: rtl/pc_gen_pkg.sv
// Shared constants for the fetch-stage program-counter generator.
package pc_gen_pkg;

  // Pipeline hold levels. This encoding is shared with the pipeline hold controller.
  localparam int unsigned HOLD_LVL_W    = 3;
  localparam logic [2:0]  HOLD_LVL_NONE = 3'd0;
  localparam logic [2:0]  HOLD_LVL_PC   = 3'd1;
  localparam logic [2:0]  HOLD_LVL_IF   = 3'd2;
  localparam logic [2:0]  HOLD_LVL_ID   = 3'd3;

  // Controller state encoding. Kept as plain constants for legacy compatibility.
  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // Sequential PC step sizes in bytes.
  localparam int unsigned PC_STEP16 = 2;
  localparam int unsigned PC_STEP32 = 4;

endpackage

// File: rtl/pc_gen_redirect_arb.sv
// Trap/jump priority and alignment check. This logic is purely combinational.
// The same result feeds the PC load and the pending-redirect latch used while halted.
module pc_redirect_arb
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned C_EXT = 1
) (
  input  logic            i_trap_flag,
  input  logic [XLEN-1:0] i_trap_addr,
  input  logic            i_jump_flag,
  input  logic [XLEN-1:0] i_jump_addr,
  output logic [XLEN-1:0] o_target,
  output logic            o_load,
  output logic            o_is_trap,
  output logic            o_misaligned
);

  logic [XLEN-1:0] w_jump_tgt;

  // Bit 0 of every target is forced to zero.
  assign w_jump_tgt = i_jump_addr & ~XLEN'(1);

  // A trap beats a jump. Without compressed support, a jump target on a 2-byte boundary is rejected.
  always_comb begin
    o_target     = '0;
    o_load       = 1'b0;
    o_is_trap    = 1'b0;
    o_misaligned = 1'b0;
    if (i_trap_flag) begin
      o_target  = i_trap_addr & ~XLEN'(1);
      o_load    = 1'b1;
      o_is_trap = 1'b1;
    end else if (i_jump_flag) begin
      o_target = w_jump_tgt;
      if (C_EXT == 0 && w_jump_tgt[1]) begin
        o_misaligned = 1'b1;
      end else begin
        o_load = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator at the head of the fetch stage.
// It supports trap/jump redirects, a pipeline hold, a valid/ready handshake and debug halt/resume.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned     C_EXT     = 1,
  parameter int unsigned     HOLD_W    = HOLD_LVL_W,
  parameter int unsigned     HOLD_PC   = 32'(HOLD_LVL_PC)
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_trap_flag,
  input  logic [XLEN-1:0]   i_trap_addr,
  input  logic              i_jump_flag,
  input  logic [XLEN-1:0]   i_jump_addr,
  input  logic [HOLD_W-1:0] i_hold_flag,
  input  logic              i_inst_len16,
  input  logic              i_halt,
  input  logic              i_resume,
  input  logic              i_pc_ready,
  output logic [XLEN-1:0]   o_pc_addr,
  output logic              o_pc_valid,
  output logic              o_redirect,
  output logic              o_misaligned,
  output logic              o_halted
);

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_redirect;
  logic            r_misaligned;
  logic            r_pend_valid;
  logic            r_pend_trap;
  logic [XLEN-1:0] r_pend_addr;

  logic [XLEN-1:0] w_target;
  logic            w_load;
  logic            w_is_trap;
  logic            w_mis;
  logic            w_stall;
  logic [XLEN-1:0] w_step;
  logic            w_pend_valid;
  logic            w_pend_trap;
  logic [XLEN-1:0] w_pend_addr;

  pc_redirect_arb #(
    .XLEN  (XLEN),
    .C_EXT (C_EXT)
  ) u_arb (
    .i_trap_flag  (i_trap_flag),
    .i_trap_addr  (i_trap_addr),
    .i_jump_flag  (i_jump_flag),
    .i_jump_addr  (i_jump_addr),
    .o_target     (w_target),
    .o_load       (w_load),
    .o_is_trap    (w_is_trap),
    .o_misaligned (w_mis)
  );

  // In RUN the valid output is always 1, so only the hold level and ready matter here.
  assign w_stall = (i_hold_flag >= HOLD_W'(HOLD_PC)) || !i_pc_ready;
  assign w_step  = (C_EXT != 0 && i_inst_len16) ? XLEN'(PC_STEP16) : XLEN'(PC_STEP32);

  // Next pending redirect while halted. A latched trap survives any later jump.
  // This value already includes a request that arrives on the resume cycle itself.
  always_comb begin
    w_pend_valid = r_pend_valid;
    w_pend_trap  = r_pend_trap;
    w_pend_addr  = r_pend_addr;
    if (w_load && !(r_pend_valid && r_pend_trap && !w_is_trap)) begin
      w_pend_valid = 1'b1;
      w_pend_trap  = w_is_trap;
      w_pend_addr  = w_target;
    end
  end

  // State, PC, pulse outputs and pending-redirect register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ST_BOOT;
      r_pc         <= RESET_VEC;
      r_redirect   <= 1'b0;
      r_misaligned <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_trap  <= 1'b0;
      r_pend_addr  <= '0;
    end else begin
      r_redirect   <= 1'b0;
      r_misaligned <= w_mis;
      case (r_state)
        ST_BOOT: begin
          r_state <= ST_RUN;
          if (w_load) begin
            r_pc       <= w_target;
            r_redirect <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_load) begin
            r_pc       <= w_target;
            r_redirect <= 1'b1;
          end else if (w_mis) begin
            // A rejected jump still outranks halt and advance. The PC holds.
          end else if (i_halt) begin
            r_state <= ST_HALTED;
          end else if (!w_stall) begin
            r_pc <= r_pc + w_step;
          end
        end
        ST_HALTED: begin
          if (i_resume) begin
            r_state      <= ST_RUN;
            r_pend_valid <= 1'b0;
            r_pend_trap  <= 1'b0;
            if (w_pend_valid) begin
              r_pc       <= w_pend_addr;
              r_redirect <= 1'b1;
            end
          end else begin
            r_pend_valid <= w_pend_valid;
            r_pend_trap  <= w_pend_trap;
            r_pend_addr  <= w_pend_addr;
          end
        end
        default: r_state <= ST_BOOT;
      endcase
    end
  end

  assign o_pc_addr    = r_pc;
  assign o_pc_valid   = (r_state == ST_RUN);
  assign o_halted     = (r_state == ST_HALTED);
  assign o_redirect   = r_redirect;
  assign o_misaligned = r_misaligned;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen.
// dut_a is configured with C_EXT=1 and RESET_VEC=0x8000_0000. dut_b is configured with C_EXT=0 and RESET_VEC=0.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trap_f, jump_f, len16, halt, resume, ready;
  logic [31:0] trap_a, jump_a;
  logic [2:0]  hold;

  logic [31:0] a_pc, b_pc;
  logic        a_v, a_r, a_m, a_h, b_v, b_r, b_m, b_h;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        v, r, m, h;
    bit          chk_b;
    logic [31:0] pc_b;
    logic        r_b, m_b;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32), .RESET_VEC(32'h8000_0000), .C_EXT(1), .HOLD_W(3), .HOLD_PC(1)) dut_a (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_trap_flag(trap_f), .i_trap_addr(trap_a),
    .i_jump_flag(jump_f), .i_jump_addr(jump_a),
    .i_hold_flag(hold), .i_inst_len16(len16),
    .i_halt(halt), .i_resume(resume), .i_pc_ready(ready),
    .o_pc_addr(a_pc), .o_pc_valid(a_v), .o_redirect(a_r),
    .o_misaligned(a_m), .o_halted(a_h)
  );

  pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .C_EXT(0), .HOLD_W(3), .HOLD_PC(1)) dut_b (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_trap_flag(trap_f), .i_trap_addr(trap_a),
    .i_jump_flag(jump_f), .i_jump_addr(jump_a),
    .i_hold_flag(hold), .i_inst_len16(len16),
    .i_halt(halt), .i_resume(resume), .i_pc_ready(ready),
    .o_pc_addr(b_pc), .o_pc_valid(b_v), .o_redirect(b_r),
    .o_misaligned(b_m), .o_halted(b_h)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare all of dut_a's outputs, and dut_b's outputs when requested, against one expectation.
  task automatic compare(input exp_t e);
    chk({e.tag, ".pc"},    a_pc,        e.pc);
    chk({e.tag, ".valid"}, 32'(a_v),    32'(e.v));
    chk({e.tag, ".redir"}, 32'(a_r),    32'(e.r));
    chk({e.tag, ".mis"},   32'(a_m),    32'(e.m));
    chk({e.tag, ".halt"},  32'(a_h),    32'(e.h));
    if (e.chk_b) begin
      chk({e.tag, ".b_pc"},    b_pc,     e.pc_b);
      chk({e.tag, ".b_redir"}, 32'(b_r), 32'(e.r_b));
      chk({e.tag, ".b_mis"},   32'(b_m), 32'(e.m_b));
    end
  endtask

  // The expectation is pushed while the current inputs are applied.
  // It is popped and compared #1 after the clock edge that consumes those inputs.
  task automatic step(input string tag, input logic [31:0] pc, input logic v, r, m, h,
                      input bit chk_b = 0, input logic [31:0] pc_b = '0,
                      input logic r_b = 1'b0, input logic m_b = 1'b0);
    exp_t e;
    e.tag = tag; e.pc = pc; e.v = v; e.r = r; e.m = m; e.h = h;
    e.chk_b = chk_b; e.pc_b = pc_b; e.r_b = r_b; e.m_b = m_b;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare(sb.pop_front());
  endtask

  task automatic idle();
    trap_f = 0; jump_f = 0; resume = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; trap_f = 0; jump_f = 0; trap_a = '0; jump_a = '0;
    hold = 3'd0; len16 = 0; halt = 0; resume = 0; ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.pc",    a_pc,     32'h8000_0000);
    chk("rst.valid", 32'(a_v), 32'd0);
    chk("rst.redir", 32'(a_r), 32'd0);
    chk("rst.mis",   32'(a_m), 32'd0);
    chk("rst.halt",  32'(a_h), 32'd0);
    chk("rst.b_pc",  b_pc,     32'h0);

    // Boot sequence
    rst_n = 1;
    #1;
    chk("boot.valid", 32'(a_v), 32'd0);
    step("boot1", 32'h8000_0000, 1, 0, 0, 0);
    step("seq1",  32'h8000_0004, 1, 0, 0, 0);
    step("seq2",  32'h8000_0008, 1, 0, 0, 0);

    // Compressed stepping from PC 0, with lengths 1,0,1
    jump_f = 1; jump_a = 32'h0;
    step("j0", 32'h0, 1, 1, 0, 0);
    idle(); len16 = 1;
    step("c16a", 32'h2, 1, 0, 0, 0);
    len16 = 0;
    step("c32",  32'h6, 1, 0, 0, 0);
    len16 = 1;
    step("c16b", 32'h8, 1, 0, 0, 0);
    len16 = 0;

    // Backpressure and hold
    jump_f = 1; jump_a = 32'h10;
    step("j10", 32'h10, 1, 1, 0, 0);
    idle(); ready = 0;
    step("bp1", 32'h10, 1, 0, 0, 0);
    step("bp2", 32'h10, 1, 0, 0, 0);
    step("bp3", 32'h10, 1, 0, 0, 0);
    ready = 1; hold = 3'd1;
    step("hold1", 32'h10, 1, 0, 0, 0);
    hold = 3'd4;
    step("hold4", 32'h10, 1, 0, 0, 0);
    hold = 3'd0;
    step("unhold", 32'h14, 1, 0, 0, 0);

    // A trap beats a jump, and a redirect overrides hold
    hold = 3'd1; trap_f = 1; trap_a = 32'h100; jump_f = 1; jump_a = 32'h200;
    step("trapjmp", 32'h100, 1, 1, 0, 0);
    idle();
    step("trappost", 32'h100, 1, 0, 0, 0);
    hold = 3'd0;

    // Alignment handling; dut_b rejects a jump target on a 2-byte boundary
    trap_f = 1; trap_a = 32'h1F1;
    step("t1f0", 32'h1F0, 1, 1, 0, 0, 1, 32'h1F0, 1, 0);
    idle(); jump_f = 1; jump_a = 32'h202;
    step("j202", 32'h202, 1, 1, 0, 0, 1, 32'h1F0, 0, 1);
    jump_a = 32'h301;
    step("j301", 32'h300, 1, 1, 0, 0, 1, 32'h300, 1, 0);
    idle();
    step("j301p", 32'h304, 1, 0, 0, 0, 1, 32'h304, 0, 0);

    // Halt with pending redirects; a latched trap survives a later jump
    jump_f = 1; jump_a = 32'h40;
    step("j40", 32'h40, 1, 1, 0, 0);
    idle(); halt = 1;
    step("halt", 32'h40, 0, 0, 0, 1);
    jump_f = 1; jump_a = 32'h80;
    step("hj80", 32'h40, 0, 0, 0, 1);
    idle(); trap_f = 1; trap_a = 32'hC0;
    step("htC0", 32'h40, 0, 0, 0, 1);
    idle(); jump_f = 1; jump_a = 32'h88;
    step("hj88", 32'h40, 0, 0, 0, 1);
    idle();
    step("hidle", 32'h40, 0, 0, 0, 1);
    halt = 0; resume = 1;
    step("resume", 32'hC0, 1, 1, 0, 0);
    idle();
    step("postres", 32'hC4, 1, 0, 0, 0);

    // Reset while halted discards the pending redirect
    halt = 1;
    step("halt2", 32'hC4, 0, 0, 0, 1);
    jump_f = 1; jump_a = 32'h80;
    step("h2j80", 32'hC4, 0, 0, 0, 1);
    idle();
    rst_n = 0;
    #1;
    chk("mrst.pc",   a_pc,     32'h8000_0000);
    chk("mrst.halt", 32'(a_h), 32'd0);
    chk("mrst.valid",32'(a_v), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    step("mboot", 32'h8000_0000, 1, 0, 0, 0);
    step("mhalt", 32'h8000_0000, 0, 0, 0, 1);
    halt = 0; resume = 1;
    step("mres",  32'h8000_0000, 1, 0, 0, 0);
    idle();
    step("madv",  32'h8000_0004, 1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator; successor to the current single-width PC register. Sits at the head of the fetch stage.
- Selects the next PC from trap redirect, jump redirect, hold, or sequential advance.
- Sequential step is 2 or 4 bytes (compressed-ISA support).
- Presents the PC to instruction fetch over a valid/ready handshake.
- Supports debug halt/resume; a redirect that arrives while halted is latched and applied on resume.

Parameters:
XLEN, 32, PC and address width.
RESET_VEC, 0, PC value after reset.
C_EXT, 1, 1 = 16-bit instructions allowed (2-byte step, 2-byte alignment); 0 = 4-byte only.
HOLD_W, 3, width of hold-level input.
HOLD_PC, 1, hold level at or above which the PC freezes.

Ports:
i_clock  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_trap_flag  in  1  trap redirect request (highest priority)
i_trap_addr  in  XLEN  trap target
i_jump_flag  in  1  branch/jump redirect request
i_jump_addr  in  XLEN  jump target
i_hold_flag  in  HOLD_W  pipeline hold level
i_inst_len16  in  1  instruction at o_pc_addr is 16-bit (ignored when C_EXT=0)
i_halt  in  1  debug halt request (level)
i_resume  in  1  debug resume pulse
i_pc_ready  in  1  fetch accepts o_pc_addr
o_pc_addr  out  XLEN  current PC
o_pc_valid  out  1  o_pc_addr is a valid fetch request
o_redirect  out  1  one-cycle pulse: PC was loaded from trap or jump
o_misaligned  out  1  one-cycle pulse: rejected misaligned jump target
o_halted  out  1  block is in HALTED state

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - State BOOT; o_pc_addr=RESET_VEC, o_pc_valid=0, o_redirect=0, o_misaligned=0, o_halted=0.
  - Pending-redirect register cleared.
- States: BOOT, RUN, HALTED.
  - BOOT -> RUN unconditionally one cycle after reset release. o_pc_valid=1 from RUN entry.
  - RUN -> HALTED when i_halt=1 and no trap/jump this cycle. In HALTED: o_pc_valid=0, o_halted=1.
  - HALTED -> RUN on i_resume=1. If a redirect is pending, the PC loads it on that same edge and o_redirect pulses. Otherwise the PC is unchanged.
- Per-cycle priority in RUN: trap > jump > halt > stall > advance.
  - Trap: PC <= {i_trap_addr[XLEN-1:1],1'b0}. Always accepted, regardless of hold or ready.
  - Jump: target t = {i_jump_addr[XLEN-1:1],1'b0}.
    - If C_EXT=0 and t[1]=1: PC unchanged, o_misaligned pulses, o_redirect=0.
    - Otherwise PC <= t.
  - Stall: PC holds when i_hold_flag >= HOLD_PC, or when o_pc_valid && !i_pc_ready.
  - Advance: when o_pc_valid && i_pc_ready && i_hold_flag < HOLD_PC.
    - PC <= PC + ((C_EXT && i_inst_len16) ? 2 : 4).
    - Wraps modulo 2^XLEN, with no flag.
- Redirects override hold and handshake. A dropped un-accepted PC is intentional: fetch must discard it.
- Redirects in HALTED:
  - Trap or jump is latched into the pending register; a later request overwrites an earlier one.
  - A trap is never overwritten by a jump.
  - The misalignment check applies at latch time; o_misaligned pulses then.
- Redirects in BOOT: trap/jump loads the PC immediately (same rules as RUN); the state still moves to RUN.
- Latency: redirect input to o_pc_addr is 1 cycle; o_redirect is asserted in the cycle the new PC is visible.
- Reset asserted mid-operation: all state returns to the reset values immediately; the pending redirect is lost.
- Hold encoding is shared with the pipeline hold controller. Comparison is unsigned.

Decomposition:
- Shared defines file:
  - Hold-level constants (HOLD_NONE, HOLD_PC, HOLD_IF, HOLD_ID).
  - State encoding (BOOT=2'd0, RUN=2'd1, HALTED=2'd2).
  - Step constants (PC_STEP16=2, PC_STEP32=4).
- One natural sub-module: pc_redirect_arb. It is combinational priority and alignment logic producing the selected target, a load enable and a misaligned flag, and is reused by the pending-redirect latch.
- State register, PC register and pending register stay in pc_gen.

Test Plan:
- Reset/boot, RESET_VEC=32'h8000_0000, ready=1, hold=0:
  - cycle 1 after release: o_pc_valid=0, PC=8000_0000.
  - next cycles: PC=8000_0000, 8000_0004, 8000_0008.
- C_EXT=1, i_inst_len16 pattern 1,0,1 from PC=0 -> PC sequence 0, 2, 6, 8.
- Backpressure and hold:
  - i_pc_ready=0 for 3 cycles at PC=0x10 -> PC stays 0x10, valid stays 1.
  - i_hold_flag=HOLD_PC with ready=1 -> PC frozen.
  - hold=0 -> PC 0x14.
- Simultaneous trap 0x100 and jump 0x200 while hold=HOLD_PC -> next PC 0x100, o_redirect=1 for exactly 1 cycle.
- C_EXT=0, jump to 0x202 -> PC unchanged, o_misaligned=1 for 1 cycle. Jump to 0x301 -> PC 0x300.
- Halt at PC 0x40, jump 0x80 then trap 0xC0 during HALTED, then i_resume:
  - PC stays 0x40 while halted; o_halted=1, valid=0.
  - On resume: PC=0xC0, o_redirect pulses.
  - Repeat with reset asserted during HALTED -> PC=RESET_VEC, pending cleared.
